// File: rtl/coef_table_loader.sv
// Byte-stream loader for the 48-bit sin/cos2 DDS coefficient table: packs 6 bytes per word, MSB first.
// Optional trailing checksum byte is enabled with `define COEF_LOADER_CHKSUM_EN.
module coef_table_loader #(
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 2048
) (
    input  logic              Fg_CLK,
    input  logic              RESETn,
    input  logic              Start,
    input  logic              Byte_Valid,
    input  logic [7:0]        Byte_Data,
    output logic              Byte_Ready,
    output logic              Wr_En,
    output logic [ADDR_W-1:0] Wr_Addr,
    output logic [47:0]       Wr_Data,
    output logic              Busy,
    output logic              Done,
    output logic              Err,
    output logic [1:0]        dbg_state
);

    // Handshake: a byte moves on a rising edge where Byte_Valid & Byte_Ready are both 1;
    // Byte_Valid with Byte_Ready low is ignored, and a Start in the same cycle drops the byte.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
`ifdef COEF_LOADER_CHKSUM_EN
        CHECK = 2'd2,
`endif
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        byte_cnt;
    logic [39:0]       shift_q;
    logic [ADDR_W-1:0] word_addr;
    logic              byte_fire;
    logic              data_fire;
    logic              word_fire;
    logic              last_word;
    logic              accepting;

    always_comb begin
        accepting = (state == LOAD);
`ifdef COEF_LOADER_CHKSUM_EN
        accepting = accepting || (state == CHECK);
`endif
    end

    assign Byte_Ready = accepting;
    assign Busy       = accepting;
    assign Done       = (state == DONE);
    assign dbg_state  = state;

    assign byte_fire = Byte_Valid & Byte_Ready & ~Start;
    assign data_fire = byte_fire & (state == LOAD);
    assign word_fire = data_fire & (byte_cnt == 3'd5);
    assign last_word = word_fire & (word_addr == LAST_ADDR);

    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (Start) begin
            state_nxt = LOAD;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                LOAD: begin
`ifdef COEF_LOADER_CHKSUM_EN
                    if (last_word) state_nxt = CHECK;
`else
                    if (last_word) state_nxt = DONE;
`endif
                end
`ifdef COEF_LOADER_CHKSUM_EN
                CHECK:   if (byte_fire) state_nxt = DONE;
`endif
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Only 5 bytes are buffered; the 6th goes straight into Wr_Data as the word completes.
    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            byte_cnt  <= 3'd0;
            shift_q   <= 40'd0;
            word_addr <= '0;
            Wr_En     <= 1'b0;
            Wr_Addr   <= '0;
            Wr_Data   <= 48'd0;
        end else begin
            Wr_En <= 1'b0;
            if (Start) begin
                byte_cnt  <= 3'd0;
                word_addr <= '0;
            end else begin
                if (data_fire) begin
                    shift_q  <= {shift_q[31:0], Byte_Data};
                    byte_cnt <= (byte_cnt == 3'd5) ? 3'd0 : byte_cnt + 3'd1;
                end
                if (word_fire) begin
                    Wr_En     <= 1'b1;
                    Wr_Addr   <= word_addr;
                    Wr_Data   <= {shift_q, Byte_Data};
                    word_addr <= word_addr + 1'b1;
                end
            end
        end
    end

`ifdef COEF_LOADER_CHKSUM_EN
    logic [7:0] chksum;
    logic       err_q;

    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            chksum <= 8'd0;
            err_q  <= 1'b0;
        end else if (Start) begin
            chksum <= 8'd0;
            err_q  <= 1'b0;
        end else begin
            if (data_fire) chksum <= chksum + Byte_Data;
            if (byte_fire && (state == CHECK)) err_q <= (Byte_Data != chksum);
        end
    end

    assign Err = err_q;
`else
    assign Err = 1'b0;
`endif

endmodule

// File: tb/tb_coef_table_loader.sv
// Bench for coef_table_loader: a DEPTH=4 instance checked through a write scoreboard,
// plus a full-size DEPTH=2048 instance fed the same inputs for the full-table load.
`timescale 1ns/1ps
module tb_coef_table_loader;

    localparam int ADDR_W = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;

    logic              byte_ready, wr_en, busy, done, err;
    logic [ADDR_W-1:0] wr_addr;
    logic [47:0]       wr_data;
    logic [1:0]        dbg_state;

    logic              big_ready, big_we, big_busy, big_done, big_err;
    logic [ADDR_W-1:0] big_addr;
    logic [47:0]       big_data;
    logic [1:0]        big_dbg;

    coef_table_loader #(.ADDR_W(ADDR_W), .DEPTH(4)) dut (
        .Fg_CLK(clk), .RESETn(rst_n), .Start(start), .Byte_Valid(byte_valid),
        .Byte_Data(byte_data), .Byte_Ready(byte_ready), .Wr_En(wr_en), .Wr_Addr(wr_addr),
        .Wr_Data(wr_data), .Busy(busy), .Done(done), .Err(err), .dbg_state(dbg_state)
    );

    coef_table_loader #(.ADDR_W(ADDR_W), .DEPTH(2048)) dut_full (
        .Fg_CLK(clk), .RESETn(rst_n), .Start(start), .Byte_Valid(byte_valid),
        .Byte_Data(byte_data), .Byte_Ready(big_ready), .Wr_En(big_we), .Wr_Addr(big_addr),
        .Wr_Data(big_data), .Busy(big_busy), .Done(big_done), .Err(big_err), .dbg_state(big_dbg)
    );

    logic [ADDR_W+47:0] exp_q[$];
    int                 n_checks = 0;
    int                 n_fail   = 0;
    logic               sb_on     = 1'b1;
    logic               big_phase = 1'b0;
    logic               prev_we   = 1'b0;
    int                 big_cnt   = 0;
    logic [ADDR_W-1:0]  big_last  = '0;
    logic [7:0]         run_sum   = 8'd0;
    logic               rdy_sel;

    assign rdy_sel = big_phase ? big_ready : byte_ready;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] big_word(input int k);
        logic [47:0] w = '0;
        for (int j = 0; j < 6; j++) w = {w[39:0], 8'((6 * k + j) & 255)};
        return w;
    endfunction

    // Scoreboard: every write of the small instance must match the head of exp_q.
    always @(negedge clk) begin
        if (sb_on && wr_en) begin
            check_eq("wr_en_width", prev_we, 1'b0);
            if (exp_q.size() == 0) begin
                check_eq("unexpected_write", wr_en, 1'b0);
            end else begin
                check_eq("wr_addr", wr_addr, exp_q[0][ADDR_W+47:48]);
                check_eq("wr_data", wr_data, exp_q[0][47:0]);
                void'(exp_q.pop_front());
            end
        end
        prev_we <= wr_en;
    end

    always @(negedge clk) begin
        if (big_phase && big_we) begin
            check_eq("big_addr", big_addr, big_cnt[ADDR_W-1:0]);
            check_eq("big_data", big_data, big_word(big_cnt));
            big_last <= big_addr;
            big_cnt  <= big_cnt + 1;
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        run_sum = 8'd0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input logic push,
                             input logic [ADDR_W+47:0] e);
        int guard = 0;
        repeat (gap) @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        while (!rdy_sel && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!rdy_sel) begin
            check_eq("ready_wait", rdy_sel, 1'b1);
            byte_valid = 1'b0;
            return;
        end
        if (push && sb_on) exp_q.push_back(e);
        run_sum = run_sum + b;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [47:0] w, input int addr, input int gap_max);
        for (int j = 0; j < 6; j++) begin
            logic [7:0] b = w[47 - 8 * j -: 8];
            send_byte(b, (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0,
                      (j == 5), {ADDR_W'(addr), w});
        end
    endtask

    task automatic load_table(input logic [7:0] base, input int gap_max);
        for (int k = 0; k < 4; k++) begin
            logic [47:0] w = '0;
            for (int j = 0; j < 6; j++) w = {w[39:0], 8'(base + 8'(6 * k + j))};
            send_word(w, k, gap_max);
        end
    endtask

    task automatic finish_load(input logic bad);
`ifdef COEF_LOADER_CHKSUM_EN
        logic [7:0] ck = run_sum + {7'd0, bad};
        check_eq("chk_busy", busy, 1'b1);
        send_byte(ck, 0, 1'b0, '0);
        check_eq("chk_err", err, bad);
`else
        check_eq("err_tied", err, 1'b0);
        if (bad) check_eq("err_tied_bad", err, 1'b0);
`endif
        check_eq("done_set", done, 1'b1);
        check_eq("busy_clr", busy, 1'b0);
        check_eq("ready_clr", byte_ready, 1'b0);
        check_eq("state_done", dbg_state, 2'd3);
    endtask

    task automatic wait_drain();
        repeat (3) @(negedge clk);
        check_eq("sb_drain", exp_q.size(), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b1;
        byte_data  = 8'h5A;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", byte_ready, 1'b0);
        check_eq("rst_wr_en", wr_en, 1'b0);
        check_eq("rst_wr_addr", wr_addr, '0);
        check_eq("rst_wr_data", wr_data, '0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_err", err, 1'b0);
        check_eq("rst_state", dbg_state, 2'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("idle_ready", byte_ready, 1'b0);
        check_eq("idle_state", dbg_state, 2'd0);
        byte_valid = 1'b0;

        // Back-to-back load of 0x00..0x17.
        pulse_start();
        check_eq("load_busy", busy, 1'b1);
        check_eq("load_done", done, 1'b0);
        check_eq("load_state", dbg_state, 2'd1);
        load_table(8'h00, 0);
        finish_load(1'b0);
        wait_drain();

        // Same load, corrupted checksum byte.
        pulse_start();
        load_table(8'h00, 0);
        finish_load(1'b1);
        wait_drain();
        pulse_start();
        check_eq("restart_err", err, 1'b0);
        check_eq("restart_done", done, 1'b0);

        // Random valid gaps, already in LOAD.
        load_table(8'h00, 2);
        finish_load(1'b0);
        wait_drain();

        // Abort after 9 bytes; the partial second word must never be written.
        pulse_start();
        send_word(48'h505152535455, 0, 0);
        for (int i = 0; i < 3; i++) send_byte(8'(8'h56 + i), 0, 1'b0, '0);
        pulse_start();
        load_table(8'hA0, 0);
        finish_load(1'b0);
        wait_drain();

        // Start together with the 6th byte of a word drops that word.
        pulse_start();
        for (int i = 0; i < 5; i++) send_byte(8'(8'h60 + i), 0, 1'b0, '0);
        start      = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'h65;
        @(negedge clk);
        start      = 1'b0;
        byte_valid = 1'b0;
        run_sum    = 8'd0;
        repeat (3) @(negedge clk);
        check_eq("abort6_busy", busy, 1'b1);
        load_table(8'hC0, 0);
        finish_load(1'b0);
        wait_drain();

        // Full 2048-word load on the full-size instance.
        sb_on     = 1'b0;
        big_phase = 1'b1;
        pulse_start();
        for (int i = 0; i < 2048 * 6; i++) send_byte(i[7:0], 0, 1'b0, '0);
`ifdef COEF_LOADER_CHKSUM_EN
        send_byte(run_sum, 0, 1'b0, '0);
`endif
        repeat (3) @(negedge clk);
        check_eq("big_count", big_cnt, 2048);
        check_eq("big_last_addr", big_last, 11'h7FF);
        check_eq("big_done", big_done, 1'b1);
        check_eq("big_busy", big_busy, 1'b0);
        check_eq("big_err", big_err, 1'b0);
        check_eq("big_state", big_dbg, 2'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
